alu_ctrl_encoder: RTL and testbench

- Registered encoder that produces the 4-bit alu_control_signal consumed by the ALU result-select mux in the RISC datapath.
- Takes decoded instruction fields (opcode, funct) through a valid/ready handshake and emits one held control word per accepted instruction to the execute stage.
- Blocks new instructions for a programmable number of cycles after each variable-shift op, giving the shifter its settle window.

---
 rtl/alu_ctrl_encoder.sv | 130 +++++++++++++
 tb/tb_alu_ctrl_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_encoder.sv
// rtl/alu_ctrl_encoder.sv - registered ALU control-word encoder with valid/ready handshake
// Variable-shift words hold off new instructions for VSHIFT_STALL cycles after they are consumed.
module alu_ctrl_encoder #(
  parameter int unsigned VSHIFT_STALL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [4:0] funct,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_control_signal,
  output logic       illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VALID = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [3:0] LP_STALL = 4'(VSHIFT_STALL);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_valid;
  logic [3:0] r_code;
  logic       r_illegal;

  logic [3:0] w_enc_code;
  logic       w_enc_illegal;
  logic       w_held_vshift;
  logic       w_in_ready;

  always_comb begin
    w_enc_code    = 4'b0000;
    w_enc_illegal = 1'b0;
    if (opcode == 6'b000000) begin
      case (funct)
        5'b00000: w_enc_code = 4'b0000;
        5'b00001: w_enc_code = 4'b0001;
        5'b00010: w_enc_code = 4'b0010;
        5'b00011: w_enc_code = 4'b0011;
        5'b00100: w_enc_code = 4'b0100;
        5'b00101: w_enc_code = 4'b0101;
        5'b00110: w_enc_code = 4'b0110;
        5'b00111: w_enc_code = 4'b0111;
        5'b01000: w_enc_code = 4'b1001;
        5'b01001: w_enc_code = 4'b1000;
        5'b01010: w_enc_code = 4'b1010;
        default:  w_enc_illegal = 1'b1;
      endcase
    end else if (opcode == 6'b000001) begin
      w_enc_code = 4'b0000;
    end else if (opcode == 6'b000010) begin
      w_enc_code = 4'b0001;
    end else begin
      w_enc_illegal = 1'b1;
    end
  end

  assign w_held_vshift = (r_code == 4'b1000) || (r_code == 4'b1001) || (r_code == 4'b1010);

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_VALID: w_in_ready = out_ready && !w_held_vshift;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign in_ready           = w_in_ready;
  assign out_valid          = r_valid;
  assign alu_control_signal = r_code;
  assign illegal            = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_valid   <= 1'b0;
      r_code    <= 4'b0000;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_code    <= w_enc_code;
            r_illegal <= w_enc_illegal;
            r_valid   <= 1'b1;
            r_state   <= S_VALID;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            if (w_held_vshift) begin
              r_valid <= 1'b0;
              if (LP_STALL != 4'd0) begin
                r_cnt   <= LP_STALL;
                r_state <= S_STALL;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (in_valid) begin
              // Back-to-back: the consumed word is replaced on the same edge.
              r_code    <= w_enc_code;
              r_illegal <= w_enc_illegal;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_STALL: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// tb/tb_alu_ctrl_encoder.sv - self-checking bench for alu_ctrl_encoder
// Reference: table-driven encoding plus cycle-window stall rule, checked every cycle.
module tb_alu_ctrl_encoder;

  localparam int VS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] opcode = 6'd0;
  logic [4:0] funct = 5'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] alu_control_signal;
  logic       illegal;

  logic       z_in_valid = 1'b0;
  logic       z_in_ready;
  logic [5:0] z_opcode = 6'd0;
  logic [4:0] z_funct = 5'd0;
  logic       z_out_valid;
  logic       z_out_ready = 1'b0;
  logic [3:0] z_code;
  logic       z_illegal;

  always #5 clk = ~clk;

  alu_ctrl_encoder #(.VSHIFT_STALL(VS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control_signal(alu_control_signal), .illegal(illegal)
  );

  alu_ctrl_encoder #(.VSHIFT_STALL(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .opcode(z_opcode), .funct(z_funct), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .alu_control_signal(z_code), .illegal(z_illegal)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int         enc_tab [0:10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 8, 10};
  logic       m_valid = 1'b0;
  logic [3:0] m_code = 4'd0;
  logic       m_ill = 1'b0;
  int         cyc = 0;
  int         stall_end = 0;
  logic       last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_enc(input logic [5:0] op, input logic [4:0] fn);
    if (op == 6'd0 && int'(fn) <= 10) return {1'b0, 4'(enc_tab[int'(fn)])};
    if (op == 6'd1) return 5'h00;
    if (op == 6'd2) return 5'h01;
    return 5'h10;
  endfunction

  function automatic logic is_vshift(input logic [3:0] c);
    return (c == 4'd8) || (c == 4'd9) || (c == 4'd10);
  endfunction

  task automatic step(input logic v, input logic [5:0] op, input logic [4:0] fn, input logic ordy);
    logic exp_rdy;
    logic cons;
    logic [4:0] e;
    @(negedge clk);
    in_valid = v; opcode = op; funct = fn; out_ready = ordy;
    #1;
    exp_rdy = (cyc < stall_end) ? 1'b0 : (!m_valid ? 1'b1 : (ordy && !is_vshift(m_code)));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("code", 32'(alu_control_signal), 32'(m_code));
    check("illegal", 32'(illegal), 32'(m_ill));
    last_acc = v && exp_rdy;
    cons = m_valid && ordy;
    if (cons && is_vshift(m_code)) stall_end = cyc + VS + 1;
    if (last_acc) begin
      e = ref_enc(op, fn);
      m_ill = e[4]; m_code = e[3:0]; m_valid = 1'b1;
    end else if (cons) begin
      m_valid = 1'b0;
    end
    cyc++;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] fn, input logic ordy, output int ncyc);
    ncyc = 0;
    do begin
      step(1'b1, op, fn, ordy);
      ncyc++;
    end while (!last_acc && ncyc < 50);
    if (!last_acc) check("send_timeout", 32'(last_acc), 32'd1);
  endtask

  initial begin
    int n;
    logic [5:0] t_op [0:4];
    logic [4:0] t_fn [0:4];
    logic [3:0] t_code [0:4];
    logic pend;
    logic [5:0] r_op;
    logic [4:0] r_fn;
    int r;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_code", 32'(alu_control_signal), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back sweep of the fixed-shift/arith functs, out_ready held high
    send(6'd0, 5'd0, 1'b1, n);
    for (int i = 1; i <= 8; i++) begin
      send(6'd0, 5'(i), 1'b1, n);
      check("b2b_accept", 32'(n), 32'd1);
    end
    // After each variable shift the next word waits for the stall window
    send(6'd0, 5'd9, 1'b1, n);
    check("vshift_gap_9", 32'(n), 32'(VS + 2));
    send(6'd0, 5'd10, 1'b1, n);
    check("vshift_gap_10", 32'(n), 32'(VS + 2));
    send(6'd1, 5'd3, 1'b1, n);
    check("vshift_gap_addi", 32'(n), 32'(VS + 2));
    send(6'd2, 5'd7, 1'b1, n);
    check("compi_accept", 32'(n), 32'd1);
    step(1'b0, 6'd0, 5'd0, 1'b1);
    step(1'b0, 6'd0, 5'd0, 1'b1);

    // Explicit encodings with hold
    t_op = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd0};
    t_fn = '{5'd8, 5'd9, 5'd10, 5'd0, 5'd3};
    t_code = '{4'b1001, 4'b1000, 4'b1010, 4'b0000, 4'b0011};
    for (int i = 0; i < 5; i++) begin
      send(t_op[i], t_fn[i], 1'b1, n);
      step(1'b0, 6'd0, 5'd0, 1'b0);
      check("enc_valid", 32'(out_valid), 32'd1);
      check("enc_code", 32'(alu_control_signal), 32'(t_code[i]));
      if (i < 4) repeat (VS + 2) step(1'b0, 6'd0, 5'd0, 1'b1);
    end

    // Backpressure: xor held, add waiting
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 6'd0, 5'd0, 1'b0);
      check("bp_code", 32'(alu_control_signal), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    step(1'b1, 6'd0, 5'd0, 1'b1);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step(1'b0, 6'd0, 5'd0, 1'b0);
    check("bp_no_bubble_valid", 32'(out_valid), 32'd1);
    check("bp_no_bubble_code", 32'(alu_control_signal), 32'd0);
    step(1'b0, 6'd0, 5'd0, 1'b1);

    // Variable-shift stall with a held instruction
    send(6'd0, 5'd10, 1'b0, n);
    step(1'b1, 6'd0, 5'd4, 1'b1);
    check("stall_consume_ready", 32'(in_ready), 32'd0);
    step(1'b1, 6'd0, 5'd4, 1'b1);
    check("stall_n1_ready", 32'(in_ready), 32'd0);
    step(1'b1, 6'd0, 5'd4, 1'b1);
    check("stall_n2_ready", 32'(in_ready), 32'd0);
    step(1'b1, 6'd0, 5'd4, 1'b1);
    check("stall_n3_ready", 32'(in_ready), 32'd1);
    step(1'b0, 6'd0, 5'd0, 1'b1);
    check("stall_accepted_code", 32'(alu_control_signal), 32'd4);

    // Illegal opcode, then a legal add clears the flag
    send(6'd63, 5'd0, 1'b1, n);
    step(1'b0, 6'd0, 5'd0, 1'b0);
    check("ill_valid", 32'(out_valid), 32'd1);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_code", 32'(alu_control_signal), 32'd0);
    send(6'd0, 5'd0, 1'b1, n);
    step(1'b0, 6'd0, 5'd0, 1'b0);
    check("ill_cleared", 32'(illegal), 32'd0);
    step(1'b0, 6'd0, 5'd0, 1'b1);

    // Reset mid-VALID while holding 1010
    send(6'd0, 5'd10, 1'b1, n);
    step(1'b0, 6'd0, 5'd0, 1'b0);
    check("pre_rst_code", 32'(alu_control_signal), 32'hA);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_code", 32'(alu_control_signal), 32'd0);
    check("async_rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_code = 4'd0; m_ill = 1'b0; stall_end = 0;
    step(1'b0, 6'd0, 5'd0, 1'b0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // VSHIFT_STALL=0 instance: shllv then add gives a single bubble
    @(negedge clk);
    z_in_valid = 1'b1; z_opcode = 6'd0; z_funct = 5'd8; z_out_ready = 1'b1;
    #1 check("z_accept_ready", 32'(z_in_ready), 32'd1);
    @(negedge clk);
    z_funct = 5'd0;
    #1;
    check("z_shllv_valid", 32'(z_out_valid), 32'd1);
    check("z_shllv_code", 32'(z_code), 32'd9);
    check("z_consume_ready", 32'(z_in_ready), 32'd0);
    @(negedge clk);
    #1;
    check("z_bubble_valid", 32'(z_out_valid), 32'd0);
    check("z_bubble_ready", 32'(z_in_ready), 32'd1);
    @(negedge clk);
    z_in_valid = 1'b0;
    #1;
    check("z_add_valid", 32'(z_out_valid), 32'd1);
    check("z_add_code", 32'(z_code), 32'd0);

    // Randomized traffic against the model
    pend = 1'b0; r_op = 6'd0; r_fn = 5'd0;
    for (int k = 0; k < 2000; k++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        r_fn = 5'($urandom_range(0, 31));
        if (r < 7) begin
          r_op = 6'd0;
          r_fn = 5'($urandom_range(0, 12));
        end else if (r == 7) r_op = 6'd1;
        else if (r == 8) r_op = 6'd2;
        else r_op = 6'($urandom_range(3, 63));
      end
      step(pend, r_op, r_fn, ($urandom_range(0, 9) < 7));
      if (last_acc) pend = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
